id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 134 +++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush handling and a
// saturating counter of load-use stall cycles.
module id_ex_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  IF_ID_Rs1,
   input  logic [4:0]  IF_ID_Rs2,
   input  logic [4:0]  IF_ID_Rd,
   input  logic        IF_ID_valid,
   input  logic        ID_uses_rs1,
   input  logic        ID_uses_rs2,
   input  logic [31:0] ID_rs1_data,
   input  logic [31:0] ID_rs2_data,
   input  logic [31:0] ID_imm,
   input  logic [31:0] ID_pc,
   input  logic        ID_regwrite,
   input  logic        ID_memread,
   input  logic        ID_memwrite,
   input  logic        ID_memtoreg,
   input  logic        ID_branch,
   input  logic        ID_alusrc,
   input  logic [1:0]  ID_aluop,
   input  logic        flush,
   output logic [4:0]  ID_EX_Rs1,
   output logic [4:0]  ID_EX_Rs2,
   output logic [4:0]  ID_EX_Rd,
   output logic        ID_EX_valid,
   output logic [31:0] ID_EX_rs1_data,
   output logic [31:0] ID_EX_rs2_data,
   output logic [31:0] ID_EX_imm,
   output logic [31:0] ID_EX_pc,
   output logic        ID_EX_regwrite,
   output logic        ID_EX_memread,
   output logic        ID_EX_memwrite,
   output logic        ID_EX_memtoreg,
   output logic        ID_EX_branch,
   output logic        ID_EX_alusrc,
   output logic [1:0]  ID_EX_aluop,
   output logic        stall,
   output logic        pc_write,
   output logic        IF_ID_write,
   output logic [15:0] stall_count
);

   logic        rs1_hit_s;
   logic        rs2_hit_s;
   logic        hazard_s;
   logic        stall_s;
   logic        bubble_s;
   logic [15:0] stall_count_r;

   // Load-use detection: a live load in EX whose destination feeds the decode slot.
   always_comb begin
      rs1_hit_s = 1'b0;
      rs2_hit_s = 1'b0;
      hazard_s  = 1'b0;
      if (ID_uses_rs1 && (ID_EX_Rd == IF_ID_Rs1)) begin
         rs1_hit_s = 1'b1;
      end else begin
         rs1_hit_s = 1'b0;
      end
      if (ID_uses_rs2 && (ID_EX_Rd == IF_ID_Rs2)) begin
         rs2_hit_s = 1'b1;
      end else begin
         rs2_hit_s = 1'b0;
      end
      // x0 is never a real producer, so a load to x0 cannot create a dependency.
      if (ID_EX_valid && ID_EX_memread && (ID_EX_Rd != 5'd0) && IF_ID_valid) begin
         hazard_s = rs1_hit_s | rs2_hit_s;
      end else begin
         hazard_s = 1'b0;
      end
   end

   // Flush wins over stall: the decode slot is squashed anyway, so holding it is pointless.
   always_comb begin
      stall_s  = hazard_s & ~flush;
      bubble_s = flush | stall_s | ~IF_ID_valid;
   end

   assign stall       = stall_s;
   assign pc_write    = ~stall_s;
   assign IF_ID_write = ~stall_s;
   assign stall_count = stall_count_r;

   // Pipeline register: reset and bubbles both leave an all-zero slot (Rd=0, regwrite=0).
   always_ff @(posedge clk) begin
      if (rst || bubble_s) begin
         ID_EX_Rs1      <= 5'd0;
         ID_EX_Rs2      <= 5'd0;
         ID_EX_Rd       <= 5'd0;
         ID_EX_valid    <= 1'b0;
         ID_EX_rs1_data <= 32'd0;
         ID_EX_rs2_data <= 32'd0;
         ID_EX_imm      <= 32'd0;
         ID_EX_pc       <= 32'd0;
         ID_EX_regwrite <= 1'b0;
         ID_EX_memread  <= 1'b0;
         ID_EX_memwrite <= 1'b0;
         ID_EX_memtoreg <= 1'b0;
         ID_EX_branch   <= 1'b0;
         ID_EX_alusrc   <= 1'b0;
         ID_EX_aluop    <= 2'd0;
      end else begin
         ID_EX_Rs1      <= IF_ID_Rs1;
         ID_EX_Rs2      <= IF_ID_Rs2;
         ID_EX_Rd       <= IF_ID_Rd;
         ID_EX_valid    <= IF_ID_valid;
         ID_EX_rs1_data <= ID_rs1_data;
         ID_EX_rs2_data <= ID_rs2_data;
         ID_EX_imm      <= ID_imm;
         ID_EX_pc       <= ID_pc;
         ID_EX_regwrite <= ID_regwrite;
         ID_EX_memread  <= ID_memread;
         ID_EX_memwrite <= ID_memwrite;
         ID_EX_memtoreg <= ID_memtoreg;
         ID_EX_branch   <= ID_branch;
         ID_EX_alusrc   <= ID_alusrc;
         ID_EX_aluop    <= ID_aluop;
      end
   end

   // Saturating stall-cycle counter; holds at all-ones rather than wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_count_r <= 16'd0;
      end else if (stall_s && (stall_count_r != 16'hFFFF)) begin
         stall_count_r <= stall_count_r + 16'd1;
      end else begin
         stall_count_r <= stall_count_r;
      end
   end

endmodule
